// File: rtl/ram_access_ctrl_pkg.sv
// ram_access_ctrl_pkg
// Shared widths and timeout defaults for the RAM access controller and its
// timer, plus a helper that sizes the read-timeout counter.
//   DEF_DATA_WIDTH : default data bus width
//   DEF_ADDR_WIDTH : default address width
//   DEF_RD_TIMEOUT : default number of READ cycles before a read gives up
//   timer_width()  : counter width needed to count up to a given timeout
package ram_access_ctrl_pkg;

  localparam int DEF_DATA_WIDTH = 8;
  localparam int DEF_ADDR_WIDTH = 4;
  localparam int DEF_RD_TIMEOUT = 16;

  // One extra bit over $clog2 so the counter can hold the timeout value itself.
  function automatic int timer_width(input int timeout);
    return $clog2(timeout) + 1;
  endfunction

endpackage

// File: rtl/ram_ctrl_timer.sv
// ram_ctrl_timer
// Clearable saturating up-counter with a done flag, used to bound how long
// the controller waits for read data.
//   clk    : rising-edge clock
//   rstn   : asynchronous active-low reset, clears the count
//   i_clr  : synchronous clear (takes priority over i_en)
//   i_en   : count enable
//   o_done : high while the count equals LIMIT
module ram_ctrl_timer #(
  parameter int WIDTH = 5,
  parameter int LIMIT = 15
) (
  input  logic clk,
  input  logic rstn,
  input  logic i_clr,
  input  logic i_en,
  output logic o_done
);

  localparam logic [WIDTH-1:0] LIMIT_C = WIDTH'(LIMIT);

  logic [WIDTH-1:0] r_count;

  // Counting stops at LIMIT so the count never wraps back to zero.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_count <= '0;
    end else if (i_clr) begin
      r_count <= '0;
    end else if (i_en && (r_count != LIMIT_C)) begin
      r_count <= r_count + WIDTH'(1);
    end
  end

  assign o_done = (r_count == LIMIT_C);

endmodule

// File: rtl/ram_access_ctrl.sv
// ram_access_ctrl
// Request/response front end for a simple single-port RAM. Writes are issued
// for one cycle and complete silently (wr_done pulse); reads wait for the RAM's
// out_en strobe, bounded by RD_TIMEOUT cycles, and return data or an error
// through a valid/ready response channel. All outputs are registered.
//   clk, rstn                                : clock, async active-low reset
//   req_valid/req_ready/req_wr/req_addr/req_wdata : request channel
//   rsp_valid/rsp_ready/rsp_rdata/rsp_err    : read response channel
//   wr_done                                  : one-cycle write-issued pulse
//   ram_en/ram_wr_rd/ram_addr/ram_data_in    : RAM command (direct to RAM)
//   ram_data_out/ram_out_en                  : RAM read data and its valid
module ram_access_ctrl
  import ram_access_ctrl_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int RD_TIMEOUT = DEF_RD_TIMEOUT
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_wr,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic                  rsp_err,
  output logic                  wr_done,
  output logic                  ram_en,
  output logic                  ram_wr_rd,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  output logic [DATA_WIDTH-1:0] ram_data_in,
  input  logic [DATA_WIDTH-1:0] ram_data_out,
  input  logic                  ram_out_en
);

  localparam int TIMER_W = timer_width(RD_TIMEOUT);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_WRITE = 2'd1,
    S_READ  = 2'd2,
    S_RESP  = 2'd3
  } state_t;

  state_t                r_state;
  logic                  r_req_ready;
  logic [ADDR_WIDTH-1:0] r_cap_addr;
  logic [DATA_WIDTH-1:0] r_cap_wdata;
  logic                  r_ram_en;
  logic                  r_ram_wr_rd;
  logic [ADDR_WIDTH-1:0] r_ram_addr;
  logic [DATA_WIDTH-1:0] r_ram_data_in;
  logic                  r_wr_done;
  logic                  r_rsp_valid;
  logic [DATA_WIDTH-1:0] r_rsp_rdata;
  logic                  r_rsp_err;

  state_t                w_state_next;
  logic [ADDR_WIDTH-1:0] w_cap_addr_next;
  logic [DATA_WIDTH-1:0] w_cap_wdata_next;
  logic                  w_ram_en_next;
  logic                  w_ram_wr_rd_next;
  logic [ADDR_WIDTH-1:0] w_ram_addr_next;
  logic [DATA_WIDTH-1:0] w_ram_data_in_next;
  logic                  w_wr_done_next;
  logic                  w_rsp_valid_next;
  logic [DATA_WIDTH-1:0] w_rsp_rdata_next;
  logic                  w_rsp_err_next;
  logic                  w_accept;
  logic                  w_in_read;
  logic                  w_timer_done;

  assign w_accept  = req_valid && r_req_ready;
  assign w_in_read = (r_state == S_READ);

  // Timer sits at LIMIT = RD_TIMEOUT-1 during the last allowed READ cycle.
  ram_ctrl_timer #(
    .WIDTH (TIMER_W),
    .LIMIT (RD_TIMEOUT - 1)
  ) u_timer (
    .clk    (clk),
    .rstn   (rstn),
    .i_clr  (w_accept),
    .i_en   (w_in_read),
    .o_done (w_timer_done)
  );

  // RAM command outputs are computed one cycle ahead so that they appear
  // registered in the state they belong to; everything defaults to idle.
  always_comb begin
    w_state_next       = r_state;
    w_cap_addr_next    = r_cap_addr;
    w_cap_wdata_next   = r_cap_wdata;
    w_ram_en_next      = 1'b0;
    w_ram_wr_rd_next   = 1'b0;
    w_ram_addr_next    = '0;
    w_ram_data_in_next = '0;
    w_wr_done_next     = 1'b0;
    w_rsp_valid_next   = 1'b0;
    w_rsp_rdata_next   = r_rsp_rdata;
    w_rsp_err_next     = r_rsp_err;

    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          w_cap_addr_next  = req_addr;
          w_cap_wdata_next = req_wdata;
          w_ram_en_next    = 1'b1;
          w_ram_addr_next  = w_cap_addr_next;
          if (req_wr) begin
            w_state_next       = S_WRITE;
            w_ram_wr_rd_next   = 1'b1;
            w_ram_data_in_next = w_cap_wdata_next;
            w_wr_done_next     = 1'b1;
          end else begin
            w_state_next = S_READ;
          end
        end
      end

      S_WRITE: begin
        w_state_next = S_IDLE;
      end

      // Data arriving on the final timeout cycle wins over the error.
      S_READ: begin
        if (ram_out_en) begin
          w_state_next     = S_RESP;
          w_rsp_valid_next = 1'b1;
          w_rsp_rdata_next = ram_data_out;
          w_rsp_err_next   = 1'b0;
        end else if (w_timer_done) begin
          w_state_next     = S_RESP;
          w_rsp_valid_next = 1'b1;
          w_rsp_rdata_next = '0;
          w_rsp_err_next   = 1'b1;
        end else begin
          w_ram_en_next   = 1'b1;
          w_ram_addr_next = r_cap_addr;
        end
      end

      S_RESP: begin
        if (rsp_ready) begin
          w_state_next = S_IDLE;
        end else begin
          w_rsp_valid_next = 1'b1;
        end
      end

      default: begin
        w_state_next = S_IDLE;
      end
    endcase
  end

  // req_ready is registered from the next state so it stays low through reset
  // and rises on the first clock after release.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state       <= S_IDLE;
      r_req_ready   <= 1'b0;
      r_cap_addr    <= '0;
      r_cap_wdata   <= '0;
      r_ram_en      <= 1'b0;
      r_ram_wr_rd   <= 1'b0;
      r_ram_addr    <= '0;
      r_ram_data_in <= '0;
      r_wr_done     <= 1'b0;
      r_rsp_valid   <= 1'b0;
      r_rsp_rdata   <= '0;
      r_rsp_err     <= 1'b0;
    end else begin
      r_state       <= w_state_next;
      r_req_ready   <= (w_state_next == S_IDLE);
      r_cap_addr    <= w_cap_addr_next;
      r_cap_wdata   <= w_cap_wdata_next;
      r_ram_en      <= w_ram_en_next;
      r_ram_wr_rd   <= w_ram_wr_rd_next;
      r_ram_addr    <= w_ram_addr_next;
      r_ram_data_in <= w_ram_data_in_next;
      r_wr_done     <= w_wr_done_next;
      r_rsp_valid   <= w_rsp_valid_next;
      r_rsp_rdata   <= w_rsp_rdata_next;
      r_rsp_err     <= w_rsp_err_next;
    end
  end

  assign req_ready   = r_req_ready;
  assign rsp_valid   = r_rsp_valid;
  assign rsp_rdata   = r_rsp_rdata;
  assign rsp_err     = r_rsp_err;
  assign wr_done     = r_wr_done;
  assign ram_en      = r_ram_en;
  assign ram_wr_rd   = r_ram_wr_rd;
  assign ram_addr    = r_ram_addr;
  assign ram_data_in = r_ram_data_in;

endmodule
